// File: rtl/clock_gen_bank.sv
// Bank of independent programmable clock dividers with glitch-free,
// period-aligned setting updates and per-channel tick / load_ack pulses.

module clock_gen_channel #(
   parameter int WIDTH = 32
) (
   input  logic             input_clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] divider,
   input  logic [WIDTH-1:0] high_count,
   output logic             output_clock,
   output logic             tick,
   output logic             load_ack
);
   logic [WIDTH-1:0] div_act, high_act, div_pend, high_pend, cnt;
   logic             pend, run;
   logic             idle, last, apply, run_nxt;
   logic [WIDTH-1:0] div_nxt, high_nxt, cnt_nxt;

   // run is the registered "inside a period" flag; leaving idle counts as a boundary
   always_comb begin
      idle     = !enable || !run;
      last     = run && enable && (div_act != '0) && (cnt == div_act - WIDTH'(1));
      apply    = (idle || last) && (pend || load);
      div_nxt  = div_act;
      high_nxt = high_act;
      if (apply) begin
         div_nxt  = load ? divider    : div_pend;
         high_nxt = load ? high_count : high_pend;
      end
      run_nxt = enable && (div_nxt != '0);
      cnt_nxt = (run_nxt && run && !last) ? cnt + WIDTH'(1) : '0;
   end

   always_ff @(posedge input_clock) begin
      if (!reset) begin
         div_act      <= '0;
         high_act     <= '0;
         div_pend     <= '0;
         high_pend    <= '0;
         pend         <= 1'b0;
         run          <= 1'b0;
         cnt          <= '0;
         output_clock <= 1'b0;
         tick         <= 1'b0;
         load_ack     <= 1'b0;
      end else begin
         if (load) begin
            div_pend  <= divider;
            high_pend <= high_count;
         end
         pend         <= apply ? 1'b0 : (pend || load);
         div_act      <= div_nxt;
         high_act     <= high_nxt;
         run          <= run_nxt;
         cnt          <= cnt_nxt;
         output_clock <= run_nxt && (cnt_nxt < high_nxt);
         tick         <= run_nxt && (cnt_nxt == '0);
         load_ack     <= apply;
      end
   end
endmodule

module clock_gen_bank #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32
) (
   input  logic                    input_clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       enable,
   input  logic [NUM_CH-1:0]       load,
   input  logic [NUM_CH*WIDTH-1:0] divider,
   input  logic [NUM_CH*WIDTH-1:0] high_count,
   output logic [NUM_CH-1:0]       output_clock,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       load_ack
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clock_gen_channel #(.WIDTH(WIDTH)) u_ch (
         .input_clock (input_clock),
         .reset       (reset),
         .enable      (enable[i]),
         .load        (load[i]),
         .divider     (divider[i*WIDTH +: WIDTH]),
         .high_count  (high_count[i*WIDTH +: WIDTH]),
         .output_clock(output_clock[i]),
         .tick        (tick[i]),
         .load_ack    (load_ack[i])
      );
   end
endmodule

// File: doc/clock_gen_bank.md
CLOCK_GEN_BANK -- requirements
Module: clock_gen_bank

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, default 4: number of independent divider channels.
- WIDTH, default 32: width of the divider and high-count fields.
REQ-002 Ports SHALL be as follows; "channel field" means channel i occupies bits [i*WIDTH +: WIDTH]:
- input_clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  NUM_CH  per-channel run enable.
- load  in  NUM_CH  per-channel one-cycle request to capture new settings.
- divider  in  NUM_CH*WIDTH  period in input_clock cycles, one channel field per channel.
- high_count  in  NUM_CH*WIDTH  high-phase length in cycles, one channel field per channel.
- output_clock  out  NUM_CH  registered divided clock per channel.
- tick  out  NUM_CH  registered one-cycle pulse marking the first cycle of each period.
- load_ack  out  NUM_CH  registered one-cycle pulse when new settings take effect.

Function
REQ-003 Each channel SHALL hold:
- active registers div_act and high_act;
- pending registers div_pend and high_pend, plus a pend flag;
- a WIDTH-bit counter, cnt.
REQ-004 Channels SHALL be fully independent; no channel's state affects another.
REQ-005 When load[i]=1, channel i SHALL capture its divider and high_count fields into the pending registers and set pend; a later load SHALL overwrite the pending values.
REQ-006 Channel i is "idle" when enable[i]=0 or div_act=0.
REQ-007 A "boundary" SHALL occur on an edge where the channel is idle, or where cnt == div_act-1 and enable=1.
REQ-008 At a boundary with pend=1 or load=1, the active registers SHALL take the new values and pend SHALL clear:
- load=1 that cycle: take the live inputs (bypass of the pending registers);
- otherwise: take the pending registers.
load_ack SHALL pulse for exactly 1 cycle after that edge.
REQ-009 Only one load_ack SHALL be issued per application, regardless of how many loads were coalesced into it.
REQ-010 Running (enable=1, div_act≥1 after any update): cnt SHALL advance 0,1,…,div_act-1 and then wrap to 0.
- div_act=1: cnt stays at 0.
REQ-011 The counter SHALL use modulo-2^WIDTH arithmetic.
- The comparison cnt == div_act-1 SHALL be evaluated only when div_act≥1; no underflow wrap is permitted.
REQ-012 output_clock SHALL be registered and SHALL equal (cnt < high_act), evaluated on the post-edge cnt and high_act values.
- high_act=0: output stays at constant 0.
- high_act≥div_act: output stays at constant 1.
REQ-013 tick SHALL be 1 exactly in cycles where the channel is running and the post-edge cnt is 0.
- div_act=1: tick is high every cycle.
REQ-014 Idle behaviour: cnt=0, output_clock=0, tick=0.
- A load issued while idle SHALL take effect on the same edge.
REQ-015 Leaving idle (enable rises, or a nonzero divider is applied) SHALL start a new period:
- the first running cycle shows cnt=0, tick=1, output_clock=(high_act>0).
REQ-016 Deasserting enable mid-period SHALL force the idle state on the next edge; the active settings SHALL be retained.
REQ-017 Settings SHALL never change mid-period. Every period SHALL be exactly div_act cycles long with exactly min(high_act, div_act) high cycles, so the output is glitch-free across updates.

Reset
REQ-018 When reset=0 at a rising edge, all channels SHALL be cleared:
- cnt=0, div_act=0, high_act=0, pending registers=0, pend=0;
- output_clock=0, tick=0, load_ack=0.
REQ-019 Reset SHALL take priority over load and enable on the same edge; a load coincident with reset SHALL be discarded.
REQ-020 After reset, every channel SHALL stay idle until a nonzero divider has been loaded.

Verification
REQ-021 Load divider=4, high_count=2 with enable=1 on ch0 after reset.
- Expected: load_ack on the next cycle; output_clock 1,1,0,0 repeating; tick every 4th cycle, coincident with the first high cycle.
REQ-022 Running at divider=4/high=2, issue load of divider=6/high=3 at cnt=1.
- Expected: the current period completes as 4 cycles (2 high); load_ack follows the wrap edge; the next period is 6 cycles with 3 high.
- Two loads in one period: only the last takes effect, with a single load_ack.
REQ-023 Corner settings:
- divider=1, high=1: output_clock constantly 1, tick every cycle.
- divider=5, high=0: output_clock constantly 0, tick every 5 cycles.
- divider=5, high=9: output_clock constantly 1.
- divider=0: idle, output_clock 0.
REQ-024 Drop enable at cnt=2 of a divider=8 period, then restore it 3 cycles later.
- Expected: output_clock=0 and tick=0 while idle; on re-enable cnt restarts at 0 with tick=1 and the period is 8 cycles.
REQ-025 Assert reset=0 mid-period on 4 channels running different dividers, with a load on the same edge.
- Expected: all outputs 0 after the edge; channels stay idle after reset release; the coincident load has no effect.
REQ-026 Run NUM_CH=4 channels at dividers 2, 3, 7 and 1000 for 10000 cycles.
- Expected: each channel's period and duty are exact throughout, and channels do not interfere.
